// File: rtl/async_down_counter_pkg.sv
// Shared definitions for the ripple counter family: JK operation encoding,
// default width and an all-ones mask helper.
package async_cnt_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        RESET  = 2'b01,
        SET    = 2'b10,
        TOGGLE = 2'b11
    } jk_op_t;

    localparam int unsigned CNT_WIDTH_DEFAULT = 3;

    function automatic logic [31:0] all_ones(input int unsigned width);
        if (width >= 32)
            return '1;
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/async_down_counter_if.sv
// Count-control and status bundle for async_down_counter; the slave modport
// is the counter side, the master modport is the controlling logic.
interface async_down_counter_if
    import async_cnt_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH_DEFAULT
) ();

    logic             en;
    logic             clr;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             underflow;

    modport master (output en, output clr, input q, input tc, input underflow);
    modport slave  (input en, input clr, output q, output tc, output underflow);

endinterface

// File: rtl/async_down_counter_jk_ff_rn.sv
// Negedge-triggered JK cell with asynchronous active-low preset to 1.
module jk_ff_rn
    import async_cnt_pkg::*;
(
    input  logic clk,
    input  logic pre_n,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(negedge clk or negedge pre_n) begin
        if (!pre_n) begin
            q <= 1'b1;
        end else begin
            unique case (jk_op_t'({j, k}))
                HOLD:    q <= q;
                RESET:   q <= 1'b0;
                SET:     q <= 1'b1;
                TOGGLE:  q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/async_down_counter.sv
// Ripple down counter with rising-edge output register, terminal-count pulse
// and optional sticky underflow flag (ASYNC_DOWN_CNT_UNDERFLOW_EN).
module async_down_counter
    import async_cnt_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    async_down_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] ALL_ONES = WIDTH'(all_ones(WIDTH));

    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] stage_clk;
    logic [WIDTH-1:0] q_r;
    logic             tc_r;

    // Each later stage fires on the rising edge of the previous bit, i.e. on a borrow.
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        if (i == 0) begin : g_first
            assign stage_clk[i] = clk;
            jk_ff_rn u_jk (
                .clk   (stage_clk[i]),
                .pre_n (rst_n),
                .j     (bus.en),
                .k     (bus.en),
                .q     (r[i])
            );
        end else begin : g_next
            assign stage_clk[i] = ~r[i-1];
            jk_ff_rn u_jk (
                .clk   (stage_clk[i]),
                .pre_n (rst_n),
                .j     (1'b1),
                .k     (1'b1),
                .q     (r[i])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r  <= ALL_ONES;
            tc_r <= 1'b0;
        end else begin
            q_r  <= r;
            tc_r <= (r == '0) && (q_r != '0);
        end
    end

    assign bus.q  = q_r;
    assign bus.tc = tc_r;

`ifdef ASYNC_DOWN_CNT_UNDERFLOW_EN
    logic uf_r;

    // Wrap takes priority over clr so a same-edge clear cannot lose the event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            uf_r <= 1'b0;
        else if ((q_r == '0) && (r == ALL_ONES))
            uf_r <= 1'b1;
        else if (bus.clr)
            uf_r <= 1'b0;
    end

    assign bus.underflow = uf_r;
`else
    logic unused_clr;
    assign unused_clr    = bus.clr;
    assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_async_down_counter.sv
// Randomised self-checking bench for async_down_counter at WIDTH 3 and 4,
// against a modular-arithmetic reference model.
module tb_async_down_counter;

`ifdef ASYNC_DOWN_CNT_UNDERFLOW_EN
    localparam bit UFEN = 1'b1;
`else
    localparam bit UFEN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    async_down_counter_if #(.WIDTH(3)) if3 ();
    async_down_counter_if #(.WIDTH(4)) if4 ();

    async_down_counter #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
    async_down_counter #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    initial forever #5 clk = ~clk;

    // Reference model: settled count plus the expected registered outputs.
    int mod_v[2] = '{8, 16};
    int mcnt[2]  = '{7, 15};
    int mq[2]    = '{7, 15};
    bit mtc[2]   = '{1'b0, 1'b0};
    bit muf[2]   = '{1'b0, 1'b0};
    bit clr_v    = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit en, input bit clr);
        if3.en  = en;
        if4.en  = en;
        if3.clr = clr;
        if4.clr = clr;
        clr_v   = clr;
    endtask

    initial forever begin
        @(negedge rst_n);
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = mod_v[i] - 1;
            mq[i]   = mod_v[i] - 1;
            mtc[i]  = 1'b0;
            muf[i]  = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && if3.en)
            for (int i = 0; i < 2; i++)
                mcnt[i] = (mcnt[i] + mod_v[i] - 1) % mod_v[i];
    end

    // Single compare process: model steps on each rising edge, DUT checked 2 units later.
    initial forever begin
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                bit wrapped;
                wrapped = (mq[i] == 0) && (mcnt[i] == mod_v[i] - 1);
                mtc[i] = (mcnt[i] == 0) && (mq[i] != 0);
                muf[i] = UFEN && (wrapped || (muf[i] && !clr_v));
                mq[i]  = mcnt[i];
            end
        end
        #2;
        chk("w3_q",  int'(if3.q),         mq[0]);
        chk("w3_tc", int'(if3.tc),        int'(mtc[0]));
        chk("w3_uf", int'(if3.underflow), int'(muf[0]));
        chk("w4_q",  int'(if4.q),         mq[1]);
        chk("w4_tc", int'(if4.tc),        int'(mtc[1]));
        chk("w4_uf", int'(if4.underflow), int'(muf[1]));
    end

    initial begin
        int exp_seq[8] = '{6, 5, 4, 3, 2, 1, 0, 7};
        int tc_cnt;
        drive(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_q3", int'(if3.q), 7);
        chk("rst_q4", int'(if4.q), 15);
        chk("rst_tc3", int'(if3.tc), 0);
        chk("rst_uf3", int'(if3.underflow), 0);

        rst_n = 1'b1;
        drive(1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #2;
            chk("seq_q3", int'(if3.q), exp_seq[k]);
            chk("seq_tc3", int'(if3.tc), (k == 6) ? 1 : 0);
        end
        chk("wrap_uf3", int'(if3.underflow), int'(UFEN));

        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("pre_hold_q3", int'(if3.q), 5);
        drive(1'b0, 1'b0);
        repeat (4) begin
            @(posedge clk); #2;
            chk("hold_q3", int'(if3.q), 5);
            chk("hold_tc3", int'(if3.tc), 0);
        end
        drive(1'b1, 1'b0);
        @(posedge clk); #2;
        chk("resume_q3", int'(if3.q), 4);

        drive(1'b1, 1'b1);
        @(posedge clk); #2;
        chk("clr_uf3", int'(if3.underflow), 0);
        drive(1'b1, 1'b0);
        repeat (3) begin
            @(posedge clk); #2;
        end
        chk("pre_wrap_q3", int'(if3.q), 0);
        drive(1'b1, 1'b1);
        @(posedge clk); #2;
        chk("wrapclr_q3", int'(if3.q), 7);
        chk("wrapclr_uf3", int'(if3.underflow), int'(UFEN));
        drive(1'b1, 1'b0);

        repeat (5) begin
            @(posedge clk); #2;
        end
        chk("mid_q3", int'(if3.q), 2);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_q3", int'(if3.q), 7);
        chk("arst_tc3", int'(if3.tc), 0);
        chk("arst_uf3", int'(if3.underflow), 0);
        chk("arst_q4", int'(if4.q), 15);
        @(posedge clk); #2;
        chk("arst_hold_q3", int'(if3.q), 7);
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("restart_q3", int'(if3.q), 6);
        chk("restart_q4", int'(if4.q), 14);

        tc_cnt = 0;
        repeat (15) begin
            @(posedge clk); #2;
            if (if4.tc) tc_cnt++;
        end
        chk("w4_tc_count", tc_cnt, 1);
        chk("w4_wrap_q", int'(if4.q), 15);
        chk("w4_wrap_uf", int'(if4.underflow), int'(UFEN));

        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
            @(posedge clk);
            if ($urandom_range(0, 99) == 0) begin
                #3 rst_n = 1'b0;
                @(posedge clk);
                #2 rst_n = 1'b1;
            end else begin
                #2;
            end
        end

        @(posedge clk); #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
